// File: rtl/uart_pkg.sv
// Shared register map, bit positions and types for the UART receive controller.
package uart_pkg;

  localparam logic [3:0] CTRL_OFF   = 4'h0;
  localparam logic [3:0] BAUD_OFF   = 4'h4;
  localparam logic [3:0] STATUS_OFF = 4'h8;
  localparam logic [3:0] DATA_OFF   = 4'hC;

  localparam int unsigned BAUD_W = 14;

  localparam int unsigned CTRL_EN         = 0;
  localparam int unsigned CTRL_IRQ_EN     = 1;
  localparam int unsigned CTRL_THRESH_LSB = 2;
  localparam int unsigned CTRL_FLUSH      = 8;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVR       = 2;
  localparam int unsigned STAT_COUNT_LSB = 3;

  typedef struct packed {
    logic [2:0] thresh;
    logic       irq_en;
    logic       en;
  } ctrl_t;

  typedef enum logic {
    PH_IDLE,
    PH_RESP
  } bus_phase_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush; a pop in the same cycle as a push frees room for it.
module uart_sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);
  assign drop_o  = push_i & ~flush_i & full_o & ~do_pop;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage is deliberately not reset; occupancy is tracked by the
  // pointers and count, so a stale entry can never be observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Register front-end for the UART receiver: baud/enable control, receive FIFO,
// overrun tracking and level interrupt behind a four-register bus window.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned        FIFO_DEPTH = 8,
  parameter logic [BAUD_W-1:0]  BAUD_RESET = 14'd5208,
  parameter int unsigned        ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              rx_rst,
  output logic [BAUD_W-1:0] baud_div,
  output logic              irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  bus_phase_e        phase_q;
  ctrl_t             ctrl_q, ctrl_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [1:0]        hold_q;
  logic              ovr_q, irq_q;
  logic [31:0]       rdata_q, rd_val;

  logic [ADDR_W-1:0] word_addr;
  logic              accept, wr, rd;
  logic              hit_ctrl, hit_baud, hit_status, hit_data;
  logic              push, pop, flush, ovr_clr, lvl_hit;
  logic [7:0]        fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic              unused_bits;

  assign word_addr  = {bus_addr[ADDR_W-1:2], 2'b00};
  assign hit_ctrl   = (word_addr == ADDR_W'(CTRL_OFF));
  assign hit_baud   = (word_addr == ADDR_W'(BAUD_OFF));
  assign hit_status = (word_addr == ADDR_W'(STATUS_OFF));
  assign hit_data   = (word_addr == ADDR_W'(DATA_OFF));

  assign accept  = bus_sel & (phase_q == PH_IDLE);
  assign wr      = accept & bus_we;
  assign rd      = accept & ~bus_we;

  // Receiver is held in reset while disabled and for two cycles after a BAUD write.
  assign rx_rst  = reset | ~ctrl_q.en | (hold_q != 2'd0);
  assign push    = rx_done & ctrl_q.en & ~rx_rst;
  assign pop     = rd & hit_data & ~fifo_empty;
  assign flush   = wr & hit_ctrl & bus_wdata[CTRL_FLUSH];
  assign ovr_clr = wr & hit_status & bus_wdata[STAT_OVR];
  assign lvl_hit = 5'(fifo_count) >= ({2'b00, ctrl_q.thresh} + 5'd1);

  assign unused_bits = ^{bus_wdata[31:BAUD_W], bus_addr[1:0]};

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (rx_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    rd_val        = '0;
    ctrl_d.en     = bus_wdata[CTRL_EN];
    ctrl_d.irq_en = bus_wdata[CTRL_IRQ_EN];
    ctrl_d.thresh = bus_wdata[CTRL_THRESH_LSB +: 3];
    baud_d        = (bus_wdata[BAUD_W-1:0] == '0) ? BAUD_W'(1) : bus_wdata[BAUD_W-1:0];
    if (hit_ctrl) begin
      rd_val[CTRL_EN]               = ctrl_q.en;
      rd_val[CTRL_IRQ_EN]           = ctrl_q.irq_en;
      rd_val[CTRL_THRESH_LSB +: 3]  = ctrl_q.thresh;
    end else if (hit_baud) begin
      rd_val[BAUD_W-1:0] = baud_q;
    end else if (hit_status) begin
      rd_val[STAT_NOT_EMPTY]       = ~fifo_empty;
      rd_val[STAT_FULL]            = fifo_full;
      rd_val[STAT_OVR]             = ovr_q;
      rd_val[STAT_COUNT_LSB +: 5]  = 5'(fifo_count);
    end else if (hit_data && !fifo_empty) begin
      rd_val[7:0] = fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PH_IDLE;
      ctrl_q  <= '0;
      baud_q  <= BAUD_RESET;
      hold_q  <= 2'd0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdata_q <= '0;
      case (phase_q)
        PH_IDLE: if (bus_sel) begin
          phase_q <= PH_RESP;
          rdata_q <= bus_we ? 32'd0 : rd_val;
        end
        PH_RESP: phase_q <= PH_IDLE;
      endcase

      if (wr && hit_ctrl) ctrl_q <= ctrl_d;

      if (wr && hit_baud) begin
        baud_q <= baud_d;
        hold_q <= 2'd2;
      end else if (hold_q != 2'd0) begin
        hold_q <= hold_q - 2'd1;
      end

      // A new overrun in the same cycle as the clear keeps the flag set.
      if (fifo_drop)    ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;

      irq_q <= ctrl_q.irq_en & (lvl_hit | ovr_q);
    end
  end

  assign bus_ready = (phase_q == PH_RESP);
  assign bus_rdata = rdata_q;
  assign baud_div  = baud_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed register scenarios plus randomized traffic
// compared every cycle against a queue-based model of the register behaviour.
module tb_uart_rx_ctrl;

  localparam int          DEPTH    = 8;
  localparam logic [13:0] BAUD_RST = 14'd5208;

  logic        clk = 1'b0;
  logic        reset, bus_sel, bus_we, bus_ready, rx_done, rx_rst, irq;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [7:0]  rx_data;
  logic [13:0] baud_div;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .BAUD_RESET (BAUD_RST),
    .ADDR_W     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_sel   (bus_sel),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .rx_rst    (rx_rst),
    .baud_div  (baud_div),
    .irq       (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, registers as plain variables.
  logic [7:0]  mq[$];
  bit          m_en, m_ie, m_ovr, e_ready, e_irq;
  logic [2:0]  m_th;
  logic [13:0] m_baud;
  int          m_hold;
  logic [31:0] e_rdata;

  always @(posedge clk) begin : model
    bit          acc, push, popped, flush, oclr, oset, n_irq;
    int          cnt, wa, n_hold;
    logic [31:0] rdv;
    if (reset) begin
      mq.delete();
      m_en = 0; m_ie = 0; m_th = '0; m_ovr = 0;
      m_baud = BAUD_RST; m_hold = 0;
      e_ready = 0; e_rdata = '0; e_irq = 0;
    end else begin
      acc    = bus_sel && !e_ready;
      push   = rx_done && m_en && (m_hold == 0);
      cnt    = mq.size();
      n_irq  = m_ie && ((cnt >= int'(m_th) + 1) || m_ovr);
      n_hold = (m_hold > 0) ? m_hold - 1 : 0;
      wa     = int'(bus_addr & 4'hC);
      rdv = '0; flush = 0; oclr = 0; popped = 0; oset = 0;
      if (acc && bus_we) begin
        case (wa)
          0: begin
            m_en = bus_wdata[0]; m_ie = bus_wdata[1]; m_th = bus_wdata[4:2];
            flush = bus_wdata[8];
          end
          4: begin
            m_baud = (bus_wdata[13:0] == 14'd0) ? 14'd1 : bus_wdata[13:0];
            n_hold = 2;
          end
          8: oclr = bus_wdata[2];
          default: ;
        endcase
      end else if (acc) begin
        case (wa)
          0:  rdv = {27'd0, m_th, m_ie, m_en};
          4:  rdv = {18'd0, m_baud};
          8:  rdv = {24'd0, 5'(cnt), m_ovr, (cnt == DEPTH), (cnt != 0)};
          12: if (cnt > 0) begin rdv = {24'd0, mq[0]}; popped = 1; end
          default: ;
        endcase
      end
      if (flush) mq.delete();
      else begin
        if (popped) mq.delete(0);
        if (push) begin
          if (mq.size() < DEPTH) mq.push_back(rx_data);
          else oset = 1;
        end
      end
      if (oset) m_ovr = 1;
      else if (oclr) m_ovr = 0;
      m_hold  = n_hold;
      e_ready = acc;
      e_rdata = rdv;
      e_irq   = n_irq;
    end
    #1;
    check("bus_ready", bus_ready, e_ready);
    if (e_ready) check("bus_rdata", bus_rdata, e_rdata);
    check("rx_rst", rx_rst, (reset || !m_en || m_hold > 0));
    check("baud_div", baud_div, m_baud);
    check("irq", irq, e_irq);
  end

  // Starts at a negedge, waits (bounded) for acceptance, returns at the
  // negedge inside the ready cycle so the next access can follow back-to-back.
  task automatic bus_acc(input bit we, input logic [3:0] a, input logic [31:0] wd,
                         input bit rxv, input logic [7:0] rxb, output logic [31:0] rd);
    bit prev, got;
    bus_sel = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd;
    rx_done = rxv;  rx_data = rxb;
    got = 0;
    for (int k = 0; k < 4 && !got; k++) begin
      prev = bus_ready;
      @(posedge clk); #1;
      rx_done = 1'b0;
      got = !prev;
    end
    check("bus_accept", 32'(got), 32'd1);
    rd = bus_rdata;
    @(negedge clk);
    bus_sel = 1'b0; bus_we = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus_acc(1'b1, a, d, 1'b0, 8'h00, r);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus_acc(1'b0, a, 32'd0, 1'b0, 8'h00, r);
    check(name, r, exp);
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_done = 1'b1; rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  initial begin
    logic [31:0] r, wd;
    logic [3:0]  a;
    bit          we;
    reset = 1'b1; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    rx_done = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_rx_rst", rx_rst, 1);
    check("rst_baud_div", baud_div, 5208);
    check("rst_irq", irq, 0);
    check("rst_ready", bus_ready, 0);
    rd_chk("rst_BAUD", 4'h4, 32'h0000_1458);
    rd_chk("rst_CTRL", 4'h0, 32'h0);

    // Single byte with THRESH=0
    wr(4'h0, 32'h3);
    rx_push(8'hA5);
    check("irq_lag", irq, 0);
    @(negedge clk);
    check("irq_high", irq, 1);
    rd_chk("status_one", 4'h8, 32'h09);
    rd_chk("data_a5", 4'hC, 32'hA5);
    rd_chk("status_after_pop", 4'h8, 32'h0);
    check("irq_low", irq, 0);

    // Overrun on the ninth byte
    for (int i = 0; i < 9; i++) rx_push(8'(8'h10 + i));
    rd_chk("status_ovr", 4'h8, 32'h47);
    for (int i = 0; i < 8; i++) rd_chk("data_seq", 4'hC, 32'(8'h10 + i));
    wr(4'h8, 32'h4);
    rd_chk("status_ovr_clr", 4'h8, 32'h0);

    // Full FIFO: pop and push in the same cycle
    for (int i = 0; i < 8; i++) rx_push(8'(8'h20 + i));
    bus_acc(1'b0, 4'hC, 32'd0, 1'b1, 8'h55, r);
    check("data_full_pop", r, 32'h20);
    rd_chk("status_full_keep", 4'h8, 32'h43);
    for (int i = 1; i < 8; i++) rd_chk("data_full_seq", 4'hC, 32'(8'h20 + i));
    rd_chk("data_last_55", 4'hC, 32'h55);
    rd_chk("status_drained", 4'h8, 32'h0);

    // BAUD write holds the receiver in reset for two cycles
    wr(4'h4, 32'h0A2C);
    check("baud_new", baud_div, 2604);
    check("hold_cycle1", rx_rst, 1);
    rx_done = 1'b1; rx_data = 8'h77;
    @(negedge clk);
    check("hold_cycle2", rx_rst, 1);
    @(negedge clk);
    check("hold_released", rx_rst, 0);
    rx_done = 1'b0;
    rd_chk("status_no_capture", 4'h8, 32'h0);
    wr(4'h4, 32'h0);
    rd_chk("baud_zero_is_one", 4'h4, 32'h1);

    // FLUSH coincident with a push
    rx_push(8'h31); rx_push(8'h32); rx_push(8'h33);
    rd_chk("status_three", 4'h8, 32'h19);
    bus_acc(1'b1, 4'h0, 32'h101, 1'b1, 8'h34, r);
    rd_chk("status_flushed", 4'h8, 32'h0);
    rd_chk("ctrl_flush_reads0", 4'h0, 32'h1);
    rd_chk("data_empty", 4'hC, 32'h0);

    // Randomized traffic; the model checks every cycle
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        rx_done = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
        @(negedge clk);
        rx_done = 1'b0;
      end else begin
        a  = {2'($urandom_range(0, 3)), 2'($urandom)};
        we = ($urandom_range(0, 2) == 0);
        wd = $urandom;
        if (a[3:2] == 2'd0) begin
          wd[0] = ($urandom_range(0, 7) != 0);
          wd[8] = ($urandom_range(0, 9) == 0);
        end
        if (a[3:2] == 2'd1) begin
          if (we && $urandom_range(0, 3) != 0) we = 1'b0;
          if ($urandom_range(0, 3) == 0) wd[13:0] = 14'd0;
        end
        bus_acc(we, a, wd, 1'($urandom_range(0, 1)), 8'($urandom), r);
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
